mssb_rx_checker: RTL and testbench
==================================

# mssb_rx_checker

Receive-side checker for the MSSB serial link. Deserialises 8N1 frames on `MSSB_RX`, compares each byte against an incrementing reference pattern, and counts received and error bytes. It produces the status word, received-byte count and error-byte count that the MSSB OPB register interface presents at its STATUS, RECV_BYTES and ERROR_BYTES addresses. It is the consumer of the transmit serialiser's output, either on the board or in loopback.

## Interface
- `CLKS_PER_BIT`, 16: OPB_CLK cycles per serial bit, minimum 4.
- `TIMEOUT_CLKS`, 1048575: idle cycles allowed between frames while armed, width 24 bits.
- One clock; reset is asynchronous and active-high.
- `OPB_CLK`  in  1  system clock.
- `OPB_RST`  in  1  asynchronous active-high reset.
- `MSSB_RX`  in  1  serial input; idle high; asynchronous to the bit grid.
- `START`  in  1  one-cycle pulse; clears the counters and arms the checker.
- `EXP_BYTES`  in  20  number of bytes expected; sampled on `START`.
- `BUSY`  out  1  high from the cycle after `START` until done.
- `STATUS`  out  2  00 = busy/idle, 01 = done without error, 11 = done with error.
- `RECV_BYTES`  out  20  frames received since `START`.
- `ERROR_BYTES`  out  20  frames with a data mismatch or a framing error.
- `TIMEOUT`  out  1  sticky; set when the run ended on a timeout.
- `BYTE_VALID`  out  1  one-cycle pulse per received frame.
- `BYTE_DATA`  out  8  received byte, valid with `BYTE_VALID`.

## Operation
- **Input sync:** `MSSB_RX` passes through a 2-flop synchroniser (reset value 1). All logic uses the synchronised copy `rx_s`.
- **States:** IDLE, ARMED, START_BIT, DATA, STOP_BIT, DONE.
- **IDLE:** waits for `START`.
- **ARMED:**
  - Falling edge of `rx_s` → START_BIT.
  - Timeout counter ≥ `TIMEOUT_CLKS` → DONE with `TIMEOUT` = 1.
  - The timeout counter clears on every entry to ARMED.
- **START_BIT:** waits `CLKS_PER_BIT/2` cycles, then samples `rx_s`.
  - Low → DATA.
  - High → glitch; return to ARMED with no count.
- **DATA:** samples every `CLKS_PER_BIT` cycles, 8 bits, LSB first, into a shift register.
- **STOP_BIT:** samples after `CLKS_PER_BIT` cycles.
  - `RECV_BYTES` increments.
  - `ERROR_BYTES` increments if the stop sample is 0 (framing error), or if data ≠ `exp_byte`.
  - `exp_byte` increments mod 256 in either case.
  - Then → ARMED, or → DONE if the new `RECV_BYTES` == `EXP_BYTES`.
- **DONE:**
  - `STATUS` = 11 if `ERROR_BYTES` ≠ 0 or `TIMEOUT`, else 01.
  - `BUSY` = 0.
  - Holds until the next `START`.
- **`START` in any state:**
  - Clears `RECV_BYTES`, `ERROR_BYTES`, `TIMEOUT`, and sets `exp_byte` = 0x00.
  - Latches `EXP_BYTES` and enters ARMED.
  - Aborts any frame in progress, including one mid-frame.
- **`EXP_BYTES` = 0:** the checker goes directly to DONE on the cycle after `START`, with `STATUS` = 01.
- **Counters:** 20 bits and never wrap, because the run ends at `EXP_BYTES` ≤ 0xFFFFF.

## Timing
- **Reset values:** state IDLE; `BUSY` = 0; `STATUS` = 00; `RECV_BYTES` = 0; `ERROR_BYTES` = 0; `TIMEOUT` = 0; `BYTE_VALID` = 0; `BYTE_DATA` = 0.
- **`START` to busy:** `START` sampled at edge N gives `BUSY` = 1 and `STATUS` = 00 from N+1.
- **Frame latency:**
  - `BYTE_VALID`, `BYTE_DATA` and the counter updates all register on the same edge as the stop-bit sample.
  - That edge falls 2 sync cycles + `CLKS_PER_BIT/2` + 9×`CLKS_PER_BIT` after the start-bit falling edge at the pin.
- **Completion:** `STATUS` and `BUSY` reflect DONE one cycle after the final `BYTE_VALID`.
- **Start bit:** the next start bit may arrive immediately after the stop-bit sample point; no gap is required.
- **`START` coinciding with a stop-bit sample:** `START` wins; the frame is discarded and not counted.
- **Reset asserted mid-frame:** all outputs return to their reset values asynchronously.

## Test plan
- **Clean run:** `EXP_BYTES` = 0x30; loopback bytes 0x00..0x2F at `CLKS_PER_BIT` = 16 → 48 `BYTE_VALID` pulses, `STATUS` = 01, `RECV_BYTES` = 0x00030, `ERROR_BYTES` = 0.
- **Data error:** `EXP_BYTES` = 8; byte 5 sent as 0xFF, all others correct → `STATUS` = 11, `RECV_BYTES` = 8, `ERROR_BYTES` = 1. Byte 6 (0x06) must be counted good.
- **Framing error:** `EXP_BYTES` = 4; byte 2 sent with stop bit = 0 → `ERROR_BYTES` = 1, `RECV_BYTES` = 4, `STATUS` = 11.
- **Glitch and zero count:**
  - Low pulse of 7 cycles on `MSSB_RX` → no `BYTE_VALID`, `RECV_BYTES` = 0, `BUSY` = 1.
  - `START` with `EXP_BYTES` = 0 → `STATUS` = 01 one cycle later.
- **Timeout:** `EXP_BYTES` = 4, `TIMEOUT_CLKS` = 1000; only 2 bytes sent → `TIMEOUT` = 1, `STATUS` = 11, `RECV_BYTES` = 2, `ERROR_BYTES` = 0.
- **Abort and reset:**
  - `START` re-pulsed mid-byte 3 → counters read 0, and the partial frame is not counted.
  - `OPB_RST` pulsed mid-frame → all outputs at their reset values within the same cycle.

Source files
------------

// File: rtl/mssb_rx_checker.sv
// -----------------------------------------------------------------------------
// mssb_rx_checker
//
// Receive-side checker for the MSSB serial link. Deserialises 8N1 frames from
// MSSB_RX, compares each byte with an incrementing reference pattern that
// starts at 0x00, and keeps received / errored byte counts for the OPB
// register interface (STATUS, RECV_BYTES, ERROR_BYTES).
//
// Parameters
//   CLKS_PER_BIT  OPB_CLK cycles per serial bit (>= 4)
//   TIMEOUT_CLKS  idle cycles allowed between frames while armed (24 bits)
//
// Ports
//   OPB_CLK      in   system clock
//   OPB_RST      in   asynchronous active-high reset
//   MSSB_RX      in   serial input, idle high, asynchronous to OPB_CLK
//   START        in   one-cycle pulse: clear counters and arm the checker
//   EXP_BYTES    in   number of bytes expected, sampled with START
//   BUSY         out  high from the cycle after START until the run is done
//   STATUS       out  00 busy/idle, 01 done clean, 11 done with error/timeout
//   RECV_BYTES   out  frames received since START
//   ERROR_BYTES  out  frames with a data mismatch or a framing error
//   TIMEOUT      out  sticky, the run ended on an inter-frame timeout
//   BYTE_VALID   out  one-cycle pulse per received frame
//   BYTE_DATA    out  received byte, valid with BYTE_VALID
// -----------------------------------------------------------------------------
module mssb_rx_checker #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic [23:0] TIMEOUT_CLKS = 24'd1048575
) (
    input  logic        OPB_CLK,
    input  logic        OPB_RST,
    input  logic        MSSB_RX,
    input  logic        START,
    input  logic [19:0] EXP_BYTES,
    output logic        BUSY,
    output logic [1:0]  STATUS,
    output logic [19:0] RECV_BYTES,
    output logic [19:0] ERROR_BYTES,
    output logic        TIMEOUT,
    output logic        BYTE_VALID,
    output logic [7:0]  BYTE_DATA
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;
    // Counter terminal values: the start bit is sampled half a bit in, every
    // later sample one full bit after the previous one.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARMED     = 3'd1,
        ST_START_BIT = 3'd2,
        ST_DATA      = 3'd3,
        ST_STOP_BIT  = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] clk_cnt_q,   clk_cnt_d;
    logic [2:0]       bit_cnt_q,   bit_cnt_d;
    logic [7:0]       shift_q,     shift_d;
    logic [7:0]       exp_byte_q,  exp_byte_d;
    logic [19:0]      exp_bytes_q, exp_bytes_d;
    logic [19:0]      recv_q,      recv_d;
    logic [19:0]      err_q,       err_d;
    logic [23:0]      tmo_cnt_q,   tmo_cnt_d;
    logic             timeout_q,   timeout_d;
    logic             byte_valid_q, byte_valid_d;
    logic [7:0]       byte_data_q, byte_data_d;
    logic             busy_q,      busy_d;
    logic [1:0]       status_q,    status_d;

    logic             rx_meta_q;
    logic             rx_s_q;
    logic             rx_prev_q;
    logic             falling_s;
    logic [19:0]      recv_inc_s;

    // Two-flop synchroniser on the serial input plus one delayed copy for edge detection.
    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= MSSB_RX;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign falling_s  = rx_prev_q & ~rx_s_q;
    assign recv_inc_s = recv_q + 20'd1;

    // State, counters and registered outputs.
    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            state_q      <= ST_IDLE;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            exp_byte_q   <= 8'h00;
            exp_bytes_q  <= 20'd0;
            recv_q       <= 20'd0;
            err_q        <= 20'd0;
            tmo_cnt_q    <= 24'd0;
            timeout_q    <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= 8'h00;
            busy_q       <= 1'b0;
            status_q     <= 2'b00;
        end else begin
            state_q      <= state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            exp_byte_q   <= exp_byte_d;
            exp_bytes_q  <= exp_bytes_d;
            recv_q       <= recv_d;
            err_q        <= err_d;
            tmo_cnt_q    <= tmo_cnt_d;
            timeout_q    <= timeout_d;
            byte_valid_q <= byte_valid_d;
            byte_data_q  <= byte_data_d;
            busy_q       <= busy_d;
            status_q     <= status_d;
        end
    end

    // Next-state logic: frame receiver, reference compare and run control.
    always_comb begin
        state_d      = state_q;
        clk_cnt_d    = clk_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        exp_byte_d   = exp_byte_q;
        exp_bytes_d  = exp_bytes_q;
        recv_d       = recv_q;
        err_d        = err_q;
        tmo_cnt_d    = 24'd0;       // non-ARMED states hold it clear, so every entry starts at 0
        timeout_d    = timeout_q;
        byte_valid_d = 1'b0;
        byte_data_d  = byte_data_q;

        if (START) begin
            // START overrides everything, including a stop-bit sample in this cycle.
            recv_d      = 20'd0;
            err_d       = 20'd0;
            timeout_d   = 1'b0;
            exp_byte_d  = 8'h00;
            exp_bytes_d = EXP_BYTES;
            clk_cnt_d   = '0;
            bit_cnt_d   = 3'd0;
            if (EXP_BYTES == 20'd0) begin
                state_d = ST_DONE;
            end else begin
                state_d = ST_ARMED;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    clk_cnt_d = '0;
                end
                ST_ARMED: begin
                    clk_cnt_d = '0;
                    if (falling_s) begin
                        state_d = ST_START_BIT;
                    end else if (tmo_cnt_q >= TIMEOUT_CLKS) begin
                        state_d   = ST_DONE;
                        timeout_d = 1'b1;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 24'd1;
                    end
                end
                ST_START_BIT: begin
                    if (clk_cnt_q == HALF_LAST) begin
                        clk_cnt_d = '0;
                        bit_cnt_d = 3'd0;
                        // A high line at mid start bit was only a glitch.
                        if (!rx_s_q) begin
                            state_d = ST_DATA;
                        end else begin
                            state_d = ST_ARMED;
                        end
                    end else begin
                        state_d = ST_START_BIT;
                    end
                end
                ST_DATA: begin
                    if (clk_cnt_q == FULL_LAST) begin
                        clk_cnt_d = '0;
                        shift_d   = {rx_s_q, shift_q[7:1]};   // LSB arrives first
                        if (bit_cnt_q == 3'd7) begin
                            state_d = ST_STOP_BIT;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_STOP_BIT: begin
                    if (clk_cnt_q == FULL_LAST) begin
                        clk_cnt_d    = '0;
                        recv_d       = recv_inc_s;
                        exp_byte_d   = exp_byte_q + 8'd1;
                        byte_valid_d = 1'b1;
                        byte_data_d  = shift_q;
                        if (!rx_s_q || (shift_q != exp_byte_q)) begin
                            err_d = err_q + 20'd1;
                        end else begin
                            err_d = err_q;
                        end
                        if (recv_inc_s == exp_bytes_q) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_ARMED;
                        end
                    end else begin
                        state_d = ST_STOP_BIT;
                    end
                end
                ST_DONE: begin
                    clk_cnt_d = '0;
                end
                default: begin
                    state_d   = ST_IDLE;
                    clk_cnt_d = '0;
                end
            endcase
        end
    end

    // BUSY/STATUS follow the registered state, so completion shows one cycle
    // after the final BYTE_VALID; START takes effect on the very next cycle.
    always_comb begin
        busy_d   = 1'b0;
        status_d = 2'b00;
        if (START) begin
            if (EXP_BYTES == 20'd0) begin
                busy_d   = 1'b0;
                status_d = 2'b01;
            end else begin
                busy_d   = 1'b1;
                status_d = 2'b00;
            end
        end else begin
            case (state_q)
                ST_ARMED, ST_START_BIT, ST_DATA, ST_STOP_BIT: begin
                    busy_d   = 1'b1;
                    status_d = 2'b00;
                end
                ST_DONE: begin
                    busy_d = 1'b0;
                    if ((err_q != 20'd0) || timeout_q) begin
                        status_d = 2'b11;
                    end else begin
                        status_d = 2'b01;
                    end
                end
                default: begin
                    busy_d   = 1'b0;
                    status_d = 2'b00;
                end
            endcase
        end
    end

    assign BUSY        = busy_q;
    assign STATUS      = status_q;
    assign RECV_BYTES  = recv_q;
    assign ERROR_BYTES = err_q;
    assign TIMEOUT     = timeout_q;
    assign BYTE_VALID  = byte_valid_q;
    assign BYTE_DATA   = byte_data_q;

endmodule

// File: tb/tb_mssb_rx_checker.sv
// -----------------------------------------------------------------------------
// tb_mssb_rx_checker
//
// Directed bench for mssb_rx_checker at CLKS_PER_BIT = 16, TIMEOUT_CLKS = 1000.
// Frames are driven on the falling clock edge one serial bit per 16 cycles;
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mssb_rx_checker;

    logic        clk;
    logic        rst;
    logic        rx;
    logic        start;
    logic [19:0] exp_bytes;
    logic        busy;
    logic [1:0]  status;
    logic [19:0] recv;
    logic [19:0] errb;
    logic        tmo;
    logic        bv;
    logic [7:0]  bd;

    int checks = 0;
    int errors = 0;
    int bv_count = 0;
    logic [7:0] last_data = 8'h00;

    mssb_rx_checker #(
        .CLKS_PER_BIT (16),
        .TIMEOUT_CLKS (24'd1000)
    ) dut (
        .OPB_CLK     (clk),
        .OPB_RST     (rst),
        .MSSB_RX     (rx),
        .START       (start),
        .EXP_BYTES   (exp_bytes),
        .BUSY        (busy),
        .STATUS      (status),
        .RECV_BYTES  (recv),
        .ERROR_BYTES (errb),
        .TIMEOUT     (tmo),
        .BYTE_VALID  (bv),
        .BYTE_DATA   (bd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count BYTE_VALID pulses and remember the last byte delivered.
    always @(negedge clk) begin
        if (bv === 1'b1) begin
            bv_count  = bv_count + 1;
            last_data = bd;
        end
    end

    // Pulse START for one cycle with the given expected byte count.
    task automatic start_run(input logic [19:0] n);
        @(negedge clk);
        start     = 1'b1;
        exp_bytes = n;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Drive one 8N1 frame; START is pulsed at cycle start_at of the frame (-1 = never).
    task automatic send_frame(input logic [7:0] data, input logic stop_b,
                              input int gap, input int start_at);
        logic [9:0] bits;
        bits = {stop_b, data, 1'b0};
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            rx    = bits[i / 16];
            start = (i == start_at);
        end
        @(negedge clk);
        rx    = 1'b1;
        start = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (status !== 2'b00)  begin errors++; $display("FAIL reset_status: got %b expected 00", status); end
        checks++; if (recv !== 20'd0)    begin errors++; $display("FAIL reset_recv: got %h expected 0", recv); end
        checks++; if (errb !== 20'd0)    begin errors++; $display("FAIL reset_err: got %h expected 0", errb); end
        checks++; if (tmo !== 1'b0)      begin errors++; $display("FAIL reset_timeout: got %b expected 0", tmo); end
        checks++; if (bv !== 1'b0)       begin errors++; $display("FAIL reset_bv: got %b expected 0", bv); end
        checks++; if (bd !== 8'h00)      begin errors++; $display("FAIL reset_bd: got %h expected 00", bd); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_clean_run;
        int base;
        base = bv_count;
        start_run(20'h00030);
        checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL start_busy: got %b expected 1", busy); end
        checks++; if (status !== 2'b00) begin errors++; $display("FAIL start_status: got %b expected 00", status); end
        for (int b = 0; b < 48; b++) send_frame(8'(b), 1'b1, 0, -1);
        repeat (2) @(negedge clk);
        checks++; if (bv_count - base != 48) begin errors++; $display("FAIL clean_pulses: got %0d expected 48", bv_count - base); end
        checks++; if (last_data !== 8'h2F)   begin errors++; $display("FAIL clean_last_data: got %h expected 2f", last_data); end
        checks++; if (status !== 2'b01)      begin errors++; $display("FAIL clean_status: got %b expected 01", status); end
        checks++; if (recv !== 20'h00030)    begin errors++; $display("FAIL clean_recv: got %h expected 00030", recv); end
        checks++; if (errb !== 20'd0)        begin errors++; $display("FAIL clean_err: got %h expected 0", errb); end
        checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL clean_busy: got %b expected 0", busy); end
    endtask

    task automatic test_data_error;
        start_run(20'd8);
        for (int b = 0; b < 8; b++) send_frame((b == 5) ? 8'hFF : 8'(b), 1'b1, 0, -1);
        repeat (2) @(negedge clk);
        checks++; if (status !== 2'b11) begin errors++; $display("FAIL dataerr_status: got %b expected 11", status); end
        checks++; if (recv !== 20'd8)   begin errors++; $display("FAIL dataerr_recv: got %h expected 8", recv); end
        checks++; if (errb !== 20'd1)   begin errors++; $display("FAIL dataerr_err: got %h expected 1", errb); end
    endtask

    task automatic test_framing_error;
        start_run(20'd4);
        for (int b = 0; b < 4; b++) send_frame(8'(b), (b == 2) ? 1'b0 : 1'b1, 16, -1);
        repeat (2) @(negedge clk);
        checks++; if (errb !== 20'd1)   begin errors++; $display("FAIL frame_err: got %h expected 1", errb); end
        checks++; if (recv !== 20'd4)   begin errors++; $display("FAIL frame_recv: got %h expected 4", recv); end
        checks++; if (status !== 2'b11) begin errors++; $display("FAIL frame_status: got %b expected 11", status); end
    endtask

    task automatic test_glitch_zero;
        int base;
        start_run(20'd4);
        base = bv_count;
        @(negedge clk);
        rx = 1'b0;
        repeat (7) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if (bv_count != base) begin errors++; $display("FAIL glitch_pulses: got %0d expected 0", bv_count - base); end
        checks++; if (recv !== 20'd0)   begin errors++; $display("FAIL glitch_recv: got %h expected 0", recv); end
        checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL glitch_busy: got %b expected 1", busy); end
        start_run(20'd0);
        checks++; if (status !== 2'b01) begin errors++; $display("FAIL zero_status: got %b expected 01", status); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL zero_busy: got %b expected 0", busy); end
    endtask

    task automatic test_timeout;
        start_run(20'd4);
        send_frame(8'h00, 1'b1, 0, -1);
        send_frame(8'h01, 1'b1, 0, -1);
        for (int i = 0; i < 1200 && tmo !== 1'b1; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        checks++; if (tmo !== 1'b1)     begin errors++; $display("FAIL timeout_flag: got %b expected 1", tmo); end
        checks++; if (status !== 2'b11) begin errors++; $display("FAIL timeout_status: got %b expected 11", status); end
        checks++; if (recv !== 20'd2)   begin errors++; $display("FAIL timeout_recv: got %h expected 2", recv); end
        checks++; if (errb !== 20'd0)   begin errors++; $display("FAIL timeout_err: got %h expected 0", errb); end
    endtask

    task automatic test_abort;
        int base;
        start_run(20'd8);
        base = bv_count;
        send_frame(8'h00, 1'b1, 0, -1);
        send_frame(8'h01, 1'b1, 0, -1);
        // Third byte aborted mid-frame by a fresh START.
        send_frame(8'h00, 1'b1, 16, 90);
        checks++; if (bv_count - base != 2) begin errors++; $display("FAIL abort_pulses: got %0d expected 2", bv_count - base); end
        checks++; if (recv !== 20'd0)       begin errors++; $display("FAIL abort_recv: got %h expected 0", recv); end
        checks++; if (errb !== 20'd0)       begin errors++; $display("FAIL abort_err: got %h expected 0", errb); end
        checks++; if (busy !== 1'b1)        begin errors++; $display("FAIL abort_busy: got %b expected 1", busy); end
        // Reference restarted at 0x00, so a 0x00 byte must count as good.
        send_frame(8'h00, 1'b1, 4, -1);
        checks++; if (recv !== 20'd1)       begin errors++; $display("FAIL abort_next_recv: got %h expected 1", recv); end
        checks++; if (errb !== 20'd0)       begin errors++; $display("FAIL abort_next_err: got %h expected 0", errb); end
    endtask

    task automatic test_start_on_stop;
        int base;
        base = bv_count;
        // START lands on the same edge as the stop-bit sample.
        send_frame(8'h00, 1'b1, 16, 154);
        checks++; if (bv_count != base) begin errors++; $display("FAIL stopstart_pulses: got %0d expected 0", bv_count - base); end
        checks++; if (recv !== 20'd0)   begin errors++; $display("FAIL stopstart_recv: got %h expected 0", recv); end
        send_frame(8'h00, 1'b1, 4, -1);
        checks++; if (recv !== 20'd1)   begin errors++; $display("FAIL stopstart_next_recv: got %h expected 1", recv); end
        checks++; if (errb !== 20'd0)   begin errors++; $display("FAIL stopstart_next_err: got %h expected 0", errb); end
    endtask

    task automatic test_reset_mid_frame;
        start_run(20'd4);
        send_frame(8'h00, 1'b1, 0, -1);
        send_frame(8'h05, 1'b1, 0, -1);
        checks++; if (bd !== 8'h05)   begin errors++; $display("FAIL prerst_bd: got %h expected 05", bd); end
        checks++; if (errb !== 20'd1) begin errors++; $display("FAIL prerst_err: got %h expected 1", errb); end
        @(negedge clk);
        rx = 1'b0;
        repeat (50) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (status !== 2'b00) begin errors++; $display("FAIL rst_status: got %b expected 00", status); end
        checks++; if (recv !== 20'd0)   begin errors++; $display("FAIL rst_recv: got %h expected 0", recv); end
        checks++; if (errb !== 20'd0)   begin errors++; $display("FAIL rst_err: got %h expected 0", errb); end
        checks++; if (tmo !== 1'b0)     begin errors++; $display("FAIL rst_timeout: got %b expected 0", tmo); end
        checks++; if (bv !== 1'b0)      begin errors++; $display("FAIL rst_bv: got %b expected 0", bv); end
        checks++; if (bd !== 8'h00)     begin errors++; $display("FAIL rst_bd: got %h expected 00", bd); end
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL postrst_busy: got %b expected 0", busy); end
    endtask

    initial begin
        rst       = 1'b1;
        rx        = 1'b1;
        start     = 1'b0;
        exp_bytes = 20'd0;
        test_reset();
        test_clean_run();
        test_data_error();
        test_framing_error();
        test_glitch_zero();
        test_timeout();
        test_abort();
        test_start_on_stop();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
